// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM bus arbiter: FSM state encoding and master ids.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam logic ARB_M_INST = 1'b0;
    localparam logic ARB_M_DATA = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant chooser. SRAM_ARB_RR_EN selects round-robin on conflict;
// otherwise data always beats inst.
import sram_arb_pkg::*;

module sram_arb_pick (
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic last_grant_i,
    output logic grant_o
);

`ifdef SRAM_ARB_RR_EN
    always_comb begin
        grant_o = ARB_M_DATA;
        if (inst_req_i && data_req_i) begin
            // On conflict the master served last yields.
            grant_o = (last_grant_i == ARB_M_DATA) ? ARB_M_INST : ARB_M_DATA;
        end else if (inst_req_i) begin
            grant_o = ARB_M_INST;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign grant_o = (inst_req_i && !data_req_i) ? ARB_M_INST : ARB_M_DATA;
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Serialises inst fetch and data load/store onto one SRAM-like port, one
// transaction outstanding. SRAM_ARB_RR_EN enables round-robin arbitration.
import sram_arb_pkg::*;

module sram_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,
    output logic [DW-1:0]   inst_rdata,
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW/8-1:0] data_wstrb,
    input  logic [DW-1:0]   data_wdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    output logic [DW-1:0]   data_rdata,
    input  logic            flush,
    output logic            mem_req,
    output logic            mem_wr,
    output logic [AW-1:0]   mem_addr,
    output logic [DW/8-1:0] mem_wstrb,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_addr_ok,
    input  logic            mem_data_ok,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_inst,
    output logic            stall_data,
    output logic [1:0]      dbg_state_o
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       cancel_q, cancel_d;
    logic       last_grant;
    logic       pick;
    logic       owner;
    logic       inst_req_eff;
    logic       any_req;
    logic       issuing;
    logic       addr_hs;
    logic       resp;

    // A flushed fetch must not start a new transaction.
    assign inst_req_eff = inst_req & ~flush;
    assign any_req      = inst_req_eff | data_req;

    sram_arb_pick u_pick (
        .inst_req_i   (inst_req_eff),
        .data_req_i   (data_req),
        .last_grant_i (last_grant),
        .grant_o      (pick)
    );

`ifdef SRAM_ARB_RR_EN
    logic last_grant_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q <= ARB_M_INST;
        end else if (state_q == ARB_IDLE && any_req) begin
            last_grant_q <= pick;
        end
    end
    assign last_grant = last_grant_q;
`else
    assign last_grant = ARB_M_INST;
`endif

    // Request fields follow the live pick in IDLE and the latched grant afterwards.
    assign owner   = (state_q == ARB_IDLE) ? pick : grant_q;
    assign issuing = ((state_q == ARB_IDLE) && any_req) || (state_q == ARB_ADDR);
    assign addr_hs = resetn & issuing & mem_addr_ok;
    assign resp    = resetn & (state_q == ARB_DATA) & mem_data_ok;

    assign mem_req   = resetn & issuing;
    assign mem_wr    = (owner == ARB_M_DATA) ? data_wr : 1'b0;
    assign mem_addr  = (owner == ARB_M_DATA) ? data_addr : inst_addr;
    assign mem_wstrb = (owner == ARB_M_DATA) ? data_wstrb : '0;
    assign mem_wdata = (owner == ARB_M_DATA) ? data_wdata : '0;

    assign inst_addr_ok = addr_hs & (owner == ARB_M_INST) & ~flush;
    assign data_addr_ok = addr_hs & (owner == ARB_M_DATA);
    assign inst_data_ok = resp & (grant_q == ARB_M_INST) & ~cancel_q & ~flush;
    assign data_data_ok = resp & (grant_q == ARB_M_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    assign stall_inst = resetn & ((inst_req & ~inst_data_ok) |
                        ((state_q != ARB_IDLE) & (grant_q == ARB_M_INST) & ~cancel_q & ~inst_data_ok));
    assign stall_data = resetn & ((data_req & ~data_data_ok) |
                        ((state_q != ARB_IDLE) & (grant_q == ARB_M_DATA) & ~data_data_ok));

    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ARB_IDLE;
            grant_q  <= ARB_M_DATA;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cancel_d = cancel_q;
        case (state_q)
            ARB_IDLE: begin
                cancel_d = 1'b0;
                if (any_req) begin
                    grant_d = pick;
                    state_d = mem_addr_ok ? ARB_DATA : ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (mem_addr_ok) begin
                    // Slave already took a flushed fetch: absorb its response silently.
                    state_d  = ARB_DATA;
                    cancel_d = (grant_q == ARB_M_INST) && flush;
                end else if ((grant_q == ARB_M_INST) && flush) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_DATA: begin
                if (mem_data_ok) begin
                    state_d  = ARB_IDLE;
                    cancel_d = 1'b0;
                end else if ((grant_q == ARB_M_INST) && flush) begin
                    cancel_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule
